// File: rtl/prco_mem_wb_pkg.sv
// prco core: shared definitions for the memory/writeback stage.
// Opcode encodings, FSM states, timeout counter width.
package prco_mem_wb_pkg;

   localparam logic [4:0] PRCO_OP_NOP = 5'h00;
   localparam logic [4:0] PRCO_OP_ADD = 5'h01;
   localparam logic [4:0] PRCO_OP_SUB = 5'h02;
   localparam logic [4:0] PRCO_OP_CMP = 5'h08;
   localparam logic [4:0] PRCO_OP_JMP = 5'h0C;
   localparam logic [4:0] PRCO_OP_LW  = 5'h10;
   localparam logic [4:0] PRCO_OP_SW  = 5'h11;

   localparam int PRCO_TMO_W = 8;

   typedef enum logic {
      PRCO_ST_IDLE = 1'b0,
      PRCO_ST_MEM  = 1'b1
   } prco_mem_st_t;

   // CMP, JMP and NOP produce no register result.
   function automatic logic prco_op_writes_reg(
      input logic [4:0] op
   );
      return !((op == PRCO_OP_CMP) ||
               (op == PRCO_OP_JMP) ||
               (op == PRCO_OP_NOP));
   endfunction

endpackage

// File: rtl/prco_mem_bus_if.sv
// prco core: data-RAM req/ack bus master.
// Holds one request until ack or timeout.
module prco_mem_bus_if
   import prco_mem_wb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_we,
   input  logic        i_is_load,
   input  logic [15:0] i_addr,
   input  logic [15:0] i_wdata,
   input  logic [2:0]  i_dest,
   input  logic        i_ack,
   output logic        o_req,
   output logic        o_we,
   output logic [15:0] o_addr,
   output logic [15:0] o_wdata,
   output logic [2:0]  o_dest,
   output logic        o_busy,
   output logic        o_load_done,
   output logic        o_timeout
);

   localparam logic [PRCO_TMO_W-1:0] LP_TMO =
      PRCO_TMO_W'(TIMEOUT_CYCLES);

   prco_mem_st_t            r_state;
   prco_mem_st_t            w_state_nxt;
   logic [PRCO_TMO_W-1:0]   r_cnt;
   logic [PRCO_TMO_W-1:0]   w_cnt_inc;
   logic                    r_we;
   logic                    r_is_load;
   logic [15:0]             r_addr;
   logic [15:0]             r_wdata;
   logic [2:0]              r_dest;
   logic                    w_done;
   logic                    w_tmo;

   assign w_cnt_inc = r_cnt + PRCO_TMO_W'(1);

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= PRCO_ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next state; ack wins over a timeout in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      w_tmo       = 1'b0;
      unique case (r_state)
         PRCO_ST_IDLE: begin
            if (i_start) w_state_nxt = PRCO_ST_MEM;
         end
         PRCO_ST_MEM: begin
            if (i_ack) begin
               w_done      = 1'b1;
               w_state_nxt = PRCO_ST_IDLE;
            end else if (w_cnt_inc == LP_TMO) begin
               w_tmo       = 1'b1;
               w_state_nxt = PRCO_ST_IDLE;
            end
         end
         default: w_state_nxt = PRCO_ST_IDLE;
      endcase
   end

   // Capture the transaction when it is accepted.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_we      <= 1'b0;
         r_is_load <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_dest    <= '0;
      end else if ((r_state == PRCO_ST_IDLE) && i_start) begin
         r_we      <= i_we;
         r_is_load <= i_is_load;
         r_addr    <= i_addr;
         r_wdata   <= i_wdata;
         r_dest    <= i_dest;
      end
   end

   // Count waited cycles; cleared whenever we leave MEM.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if ((r_state == PRCO_ST_MEM) &&
                   (w_state_nxt == PRCO_ST_MEM)) begin
         r_cnt <= w_cnt_inc;
      end else begin
         r_cnt <= '0;
      end
   end

   assign o_busy      = (r_state == PRCO_ST_MEM);
   assign o_req       = o_busy;
   assign o_we        = r_we;
   assign o_addr      = r_addr;
   assign o_wdata     = r_wdata;
   assign o_dest      = r_dest;
   assign o_load_done = w_done & r_is_load;
   assign o_timeout   = w_tmo;

endmodule

// File: rtl/prco_mem_wb.sv
// prco core: memory/writeback stage.
// Decodes ALU pulses into writeback, RAM access or PC redirect.
module prco_mem_wb
   import prco_mem_wb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_ce_reg,
   input  logic        i_ce_ram,
   input  logic        i_should_branch,
   input  logic [4:0]  i_op,
   input  logic [15:0] i_result,
   input  logic [15:0] i_store_data,
   input  logic [2:0]  i_dest_reg,
   output logic        q_mem_req,
   output logic        q_mem_we,
   output logic [15:0] q_mem_addr,
   output logic [15:0] q_mem_wdata,
   input  logic        i_mem_ack,
   input  logic [15:0] i_mem_rdata,
   output logic        q_wb_en,
   output logic [2:0]  q_wb_sel,
   output logic [15:0] q_wb_data,
   output logic        q_pc_load,
   output logic [15:0] q_pc_target,
   output logic        q_stall,
   output logic        q_fault
);

   logic        w_busy;
   logic        w_pulse;
   logic        w_take_br;
   logic        w_take_ram;
   logic        w_take_reg;
   logic        w_ld_done;
   logic        w_tmo;
   logic [2:0]  w_ld_dest;

   logic        r_wb_en;
   logic [2:0]  r_wb_sel;
   logic [15:0] r_wb_data;
   logic        r_pc_load;
   logic [15:0] r_pc_target;
   logic        r_fault;

   assign w_pulse = i_ce_reg | i_ce_ram | i_should_branch;

   // Pulse decode in IDLE: branch, then RAM, then register.
   always_comb begin
      w_take_br  = 1'b0;
      w_take_ram = 1'b0;
      w_take_reg = 1'b0;
      if (!w_busy) begin
         priority case (1'b1)
            i_should_branch: w_take_br  = 1'b1;
            i_ce_ram:        w_take_ram = 1'b1;
            i_ce_reg:
               w_take_reg = prco_op_writes_reg(i_op);
            default: ;
         endcase
      end
   end

   prco_mem_bus_if #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_bus (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (w_take_ram),
      .i_we        (i_op == PRCO_OP_SW),
      .i_is_load   (i_op == PRCO_OP_LW),
      .i_addr      (i_result),
      .i_wdata     (i_store_data),
      .i_dest      (i_dest_reg),
      .i_ack       (i_mem_ack),
      .o_req       (q_mem_req),
      .o_we        (q_mem_we),
      .o_addr      (q_mem_addr),
      .o_wdata     (q_mem_wdata),
      .o_dest      (w_ld_dest),
      .o_busy      (w_busy),
      .o_load_done (w_ld_done),
      .o_timeout   (w_tmo)
   );

   // Writeback strobe from the register path or a finished load.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wb_en   <= 1'b0;
         r_wb_sel  <= '0;
         r_wb_data <= '0;
      end else begin
         r_wb_en <= w_take_reg | w_ld_done;
         if (w_take_reg) begin
            r_wb_sel  <= i_dest_reg;
            r_wb_data <= i_result;
         end else if (w_ld_done) begin
            r_wb_sel  <= w_ld_dest;
            r_wb_data <= i_mem_rdata;
         end
      end
   end

   // PC redirect strobe; target holds between branches.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pc_load   <= 1'b0;
         r_pc_target <= '0;
      end else begin
         r_pc_load <= w_take_br;
         if (w_take_br) r_pc_target <= i_result;
      end
   end

   // Sticky fault: bus timeout or a pulse while stalled.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)                          r_fault <= 1'b0;
      else if (w_tmo || (w_busy && w_pulse)) r_fault <= 1'b1;
   end

   assign q_wb_en     = r_wb_en;
   assign q_wb_sel    = r_wb_sel;
   assign q_wb_data   = r_wb_data;
   assign q_pc_load   = r_pc_load;
   assign q_pc_target = r_pc_target;
   assign q_stall     = w_busy;
   assign q_fault     = r_fault;

endmodule

// File: tb/tb_prco_mem_wb.sv
// prco core: self-checking bench for prco_mem_wb.
// Vector table, corner sequences and a randomized model run.
module tb_prco_mem_wb;
   import prco_mem_wb_pkg::*;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ce_reg, ce_ram, br;
   logic [4:0]  op;
   logic [15:0] res, sdata;
   logic [2:0]  dest;
   logic        ack;
   logic [15:0] rdata;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr, mem_wdata;
   logic        wb_en;
   logic [2:0]  wb_sel;
   logic [15:0] wb_data;
   logic        pc_load;
   logic [15:0] pc_tgt;
   logic        stall, fault;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   prco_mem_wb #(.TIMEOUT_CYCLES(T)) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_ce_reg        (ce_reg),
      .i_ce_ram        (ce_ram),
      .i_should_branch (br),
      .i_op            (op),
      .i_result        (res),
      .i_store_data    (sdata),
      .i_dest_reg      (dest),
      .q_mem_req       (mem_req),
      .q_mem_we        (mem_we),
      .q_mem_addr      (mem_addr),
      .q_mem_wdata     (mem_wdata),
      .i_mem_ack       (ack),
      .i_mem_rdata     (rdata),
      .q_wb_en         (wb_en),
      .q_wb_sel        (wb_sel),
      .q_wb_data       (wb_data),
      .q_pc_load       (pc_load),
      .q_pc_target     (pc_tgt),
      .q_stall         (stall),
      .q_fault         (fault)
   );

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      ce_reg = 0; ce_ram = 0; br = 0;
      op = PRCO_OP_NOP; res = 0; sdata = 0; dest = 0;
      ack = 0; rdata = 0;
   endtask

   task automatic do_reset();
      clr();
      rst_n = 0;
      tick();
      rst_n = 1;
   endtask

   task automatic ram_pulse(input logic [4:0] o,
                            input logic [15:0] a,
                            input logic [15:0] d,
                            input logic [2:0] r);
      ce_ram = 1; op = o; res = a; sdata = d; dest = r;
      tick();
      clr();
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, " req"},   mem_req,   0);
      chk({nm, " we"},    mem_we,    0);
      chk({nm, " addr"},  mem_addr,  0);
      chk({nm, " wdata"}, mem_wdata, 0);
      chk({nm, " wb_en"}, wb_en,     0);
      chk({nm, " wbsel"}, wb_sel,    0);
      chk({nm, " wbdat"}, wb_data,   0);
      chk({nm, " pcld"},  pc_load,   0);
      chk({nm, " pctgt"}, pc_tgt,    0);
      chk({nm, " stall"}, stall,     0);
      chk({nm, " fault"}, fault,     0);
   endtask

   typedef struct {
      logic        ce_reg;
      logic        br;
      logic [4:0]  op;
      logic [15:0] res;
      logic [2:0]  dest;
      logic        wb;
      logic        pc;
   } vec_t;

   vec_t tbl[9];

   // reference model state
   logic        m_busy, m_we, m_load;
   int          m_cnt;
   logic [15:0] m_addr, m_wdata;
   logic [2:0]  m_dest;
   logic        e_wb_en, e_pc, e_fault;
   logic [2:0]  e_wb_sel;
   logic [15:0] e_wb_data, e_tgt;

   logic [4:0]  ops[7];

   task automatic model_step();
      if (!rst_n) begin
         m_busy = 0; m_cnt = 0; m_we = 0; m_load = 0;
         m_addr = 0; m_wdata = 0; m_dest = 0;
         e_wb_en = 0; e_wb_sel = 0; e_wb_data = 0;
         e_pc = 0; e_tgt = 0; e_fault = 0;
      end else begin
         e_wb_en = 0;
         e_pc    = 0;
         if (!m_busy) begin
            if (br) begin
               e_pc = 1; e_tgt = res;
            end else if (ce_ram) begin
               m_busy = 1; m_cnt = 0;
               m_addr = res; m_wdata = sdata;
               m_we = (op == PRCO_OP_SW);
               m_load = (op == PRCO_OP_LW);
               m_dest = dest;
            end else if (ce_reg &&
                         !(op inside {PRCO_OP_CMP, PRCO_OP_JMP,
                                      PRCO_OP_NOP})) begin
               e_wb_en = 1; e_wb_sel = dest; e_wb_data = res;
            end
         end else begin
            if (ce_reg || ce_ram || br) e_fault = 1;
            m_cnt++;
            if (ack) begin
               m_busy = 0;
               if (m_load) begin
                  e_wb_en = 1; e_wb_sel = m_dest; e_wb_data = rdata;
               end
            end else if (m_cnt == T) begin
               m_busy = 0;
               e_fault = 1;
            end
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b1, 1'b0, PRCO_OP_ADD, 16'h1234, 3'd3, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 1'b0, PRCO_OP_CMP, 16'h5555, 3'd2, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, PRCO_OP_JMP, 16'h0100, 3'd1, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b0, PRCO_OP_NOP, 16'h0001, 3'd4, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 1'b1, PRCO_OP_ADD, 16'h0040, 3'd5, 1'b0, 1'b1};
      tbl[5] = '{1'b0, 1'b1, PRCO_OP_JMP, 16'hFFFE, 3'd0, 1'b0, 1'b1};
      tbl[6] = '{1'b1, 1'b0, PRCO_OP_SUB, 16'hFFFF, 3'd7, 1'b1, 1'b0};
      tbl[7] = '{1'b1, 1'b0, PRCO_OP_LW,  16'h0000, 3'd6, 1'b1, 1'b0};
      tbl[8] = '{1'b0, 1'b0, PRCO_OP_ADD, 16'h7777, 3'd1, 1'b0, 1'b0};
      ops = '{PRCO_OP_NOP, PRCO_OP_ADD, PRCO_OP_SUB, PRCO_OP_CMP,
              PRCO_OP_JMP, PRCO_OP_LW, PRCO_OP_SW};

      do_reset();
      chk_all_zero("reset");

      // register and branch vectors
      for (int i = 0; i < 9; i++) begin
         ce_reg = tbl[i].ce_reg; br = tbl[i].br;
         op = tbl[i].op; res = tbl[i].res; dest = tbl[i].dest;
         tick();
         clr();
         chk($sformatf("v%0d wb_en", i), wb_en, tbl[i].wb);
         chk($sformatf("v%0d pcld", i), pc_load, tbl[i].pc);
         chk($sformatf("v%0d stall", i), stall, 0);
         if (tbl[i].wb) begin
            chk($sformatf("v%0d wbsel", i), wb_sel, tbl[i].dest);
            chk($sformatf("v%0d wbdat", i), wb_data, tbl[i].res);
         end
         if (tbl[i].pc)
            chk($sformatf("v%0d pctgt", i), pc_tgt, tbl[i].res);
         tick();
         chk($sformatf("v%0d wb_off", i), wb_en, 0);
         chk($sformatf("v%0d pc_off", i), pc_load, 0);
         if (tbl[i].wb)
            chk($sformatf("v%0d wbhold", i), wb_data, tbl[i].res);
      end

      // load, ack three cycles after request rises
      ram_pulse(PRCO_OP_LW, 16'h0010, 16'h0000, 3'd2);
      chk("ld req", mem_req, 1);
      chk("ld we", mem_we, 0);
      chk("ld addr", mem_addr, 16'h0010);
      chk("ld stall1", stall, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("ld stall%0d", i + 2), stall, 1);
         chk("ld wb_idle", wb_en, 0);
      end
      ack = 1; rdata = 16'hBEEF;
      tick();
      clr();
      chk("ld stall_off", stall, 0);
      chk("ld req_off", mem_req, 0);
      chk("ld wb_en", wb_en, 1);
      chk("ld wbdat", wb_data, 16'hBEEF);
      chk("ld wbsel", wb_sel, 2);
      tick();
      chk("ld wb_once", wb_en, 0);

      // store acked in its first request cycle
      ram_pulse(PRCO_OP_SW, 16'h0020, 16'h00AA, 3'd1);
      chk("st req", mem_req, 1);
      chk("st we", mem_we, 1);
      chk("st wdata", mem_wdata, 16'h00AA);
      chk("st addr", mem_addr, 16'h0020);
      ack = 1;
      tick();
      clr();
      chk("st req_off", mem_req, 0);
      chk("st wb_en", wb_en, 0);
      chk("st fault", fault, 0);

      // ack while idle is ignored
      ack = 1; rdata = 16'h1111;
      tick();
      clr();
      chk("idle ack wb", wb_en, 0);
      chk("idle ack req", mem_req, 0);

      // timeout
      ram_pulse(PRCO_OP_LW, 16'h0030, 16'h0000, 3'd3);
      chk("to req1", mem_req, 1);
      for (int i = 0; i < T - 1; i++) begin
         tick();
         chk($sformatf("to req%0d", i + 2), mem_req, 1);
         chk("to fault_early", fault, 0);
      end
      tick();
      chk("to req_off", mem_req, 0);
      chk("to stall_off", stall, 0);
      chk("to fault", fault, 1);
      chk("to wb_en", wb_en, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("to sticky", fault, 1);
         chk("to no_wb", wb_en, 0);
      end
      do_reset();
      chk("to fault_clr", fault, 0);

      // overrun, then reset in the middle of MEM
      ram_pulse(PRCO_OP_LW, 16'h0044, 16'h0000, 3'd5);
      ce_reg = 1; op = PRCO_OP_ADD; res = 16'h9999; dest = 3'd4;
      tick();
      clr();
      chk("ov fault", fault, 1);
      chk("ov wb_en", wb_en, 0);
      chk("ov stall", stall, 1);
      rst_n = 0; ack = 1; rdata = 16'hCAFE;
      tick();
      rst_n = 1;
      clr();
      chk_all_zero("mid rst");
      tick();
      chk("mid rst no_wb", wb_en, 0);

      // randomized run against the model
      rst_n = 0;
      model_step();
      tick();
      rst_n = 1;
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         if (!m_busy || $urandom_range(0, 7) == 0) begin
            ce_reg = 1'($urandom_range(0, 1));
            ce_ram = 1'($urandom_range(0, 1));
            br     = ($urandom_range(0, 3) == 0);
         end else begin
            ce_reg = 0; ce_ram = 0; br = 0;
         end
         if ($urandom_range(0, 7) == 0) op = 5'($urandom_range(0, 31));
         else op = ops[$urandom_range(0, 6)];
         res   = 16'($urandom);
         sdata = 16'($urandom);
         dest  = 3'($urandom_range(0, 7));
         rdata = 16'($urandom);
         ack   = m_busy ? ($urandom_range(0, 2) == 0)
                        : 1'($urandom_range(0, 1));
         model_step();
         tick();
         chk("rnd req", mem_req, m_busy);
         chk("rnd stall", stall, m_busy);
         if (m_busy) begin
            chk("rnd addr", mem_addr, m_addr);
            chk("rnd wdata", mem_wdata, m_wdata);
            chk("rnd we", mem_we, m_we);
         end
         chk("rnd wb_en", wb_en, e_wb_en);
         chk("rnd wbsel", wb_sel, e_wb_sel);
         chk("rnd wbdat", wb_data, e_wb_data);
         chk("rnd pcld", pc_load, e_pc);
         chk("rnd pctgt", pc_tgt, e_tgt);
         chk("rnd fault", fault, e_fault);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
